// File: rtl/raggedstone_spinn_aer_if_button_cond.sv
// raggedstone_spinn_aer_if_button_cond: synchronise, debounce and pulse-encode raw active-low push-buttons
// Ports: clk system clock; rst async active-high reset;
//        i_btn_n raw buttons (0 = pressed); o_btn_n debounced level (bit 0 drives mode_sel);
//        o_press / o_release one-cycle pulses on accepted edges; o_long one pulse per long hold.
module raggedstone_spinn_aer_if_button_cond #(
    parameter int NUM_BTNS       = 2,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] i_btn_n,
    output logic [NUM_BTNS-1:0] o_btn_n,
    output logic [NUM_BTNS-1:0] o_press,
    output logic [NUM_BTNS-1:0] o_release,
    output logic [NUM_BTNS-1:0] o_long
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS) + 1;
    localparam int LW = $clog2(LONG_TICKS) + 1;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    assign tick = tick_cnt == TW'(TICK_DIV - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_cnt <= '0;
        else     tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
    genvar i;
    for (i = 0; i < NUM_BTNS; i++) begin : g_btn
        logic          s1, s2, lvl, press, rel, lng, fired, accept;
        logic [DW-1:0] deb_cnt;
        logic [LW-1:0] long_cnt;
        // a change is accepted on the tick that completes DEBOUNCE_TICKS stable ticks
        assign accept = (s2 != lvl) && tick && deb_cnt == DW'(DEBOUNCE_TICKS - 1);
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1       <= 1'b1;
                s2       <= 1'b1;
                lvl      <= 1'b1;
                press    <= 1'b0;
                rel      <= 1'b0;
                lng      <= 1'b0;
                fired    <= 1'b0;
                deb_cnt  <= '0;
                long_cnt <= '0;
            end else begin
                s1    <= i_btn_n[i];
                s2    <= s1;
                press <= accept && !s2;
                rel   <= accept && s2;
                lng   <= 1'b0;
                // any sample matching the debounced level wipes all debounce credit
                if (accept) begin
                    lvl     <= s2;
                    deb_cnt <= '0;
                end else if (s2 == lvl) begin
                    deb_cnt <= '0;
                end else if (tick) begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
                // long_cnt saturates at LONG_TICKS-1; fired blocks repeats until release
                if (accept && s2) begin
                    long_cnt <= '0;
                    fired    <= 1'b0;
                end else if (!lvl && tick) begin
                    if (long_cnt != LW'(LONG_TICKS - 1)) begin
                        long_cnt <= long_cnt + 1'b1;
                    end else if (!fired) begin
                        lng   <= 1'b1;
                        fired <= 1'b1;
                    end
                end
            end
        end
        assign o_btn_n[i]   = lvl;
        assign o_press[i]   = press;
        assign o_release[i] = rel;
        assign o_long[i]    = lng;
    end
endmodule

// File: tb/tb_raggedstone_spinn_aer_if_button_cond.sv
// tb_raggedstone_spinn_aer_if_button_cond: directed checks of button conditioning with TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=8
module tb_raggedstone_spinn_aer_if_button_cond;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] i_btn_n = 2'b11;
    logic [1:0] o_btn_n, o_press, o_release, o_long;
    raggedstone_spinn_aer_if_button_cond #(
        .NUM_BTNS(2), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .LONG_TICKS(8)
    ) dut (
        .clk(clk), .rst(rst), .i_btn_n(i_btn_n), .o_btn_n(o_btn_n),
        .o_press(o_press), .o_release(o_release), .o_long(o_long)
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0, cyc = 0;
    int n_press0 = 0, n_press1 = 0, n_rel0 = 0, n_long0 = 0, n_long1 = 0;
    int n_fall0 = 0, n_fall1 = 0, n_low0 = 0, n_both = 0;
    int p0, r0, l0, f0;
    logic [1:0] prev_btn = 2'b11;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask
    // cyc counts posedges since the last reset release; sampling is on the falling edge
    task automatic step();
        @(negedge clk);
        cyc++;
        n_press0 += int'(o_press[0]);
        n_press1 += int'(o_press[1]);
        n_rel0   += int'(o_release[0]);
        n_long0  += int'(o_long[0]);
        n_long1  += int'(o_long[1]);
        n_low0   += int'(!o_btn_n[0]);
        n_both   += int'(|(o_press & o_release));
        if (prev_btn[0] && !o_btn_n[0]) n_fall0++;
        if (prev_btn[1] && !o_btn_n[1]) n_fall1++;
        prev_btn = o_btn_n;
    endtask
    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask
    initial begin
        repeat (3) step();
        check("rst_btn", 32'(o_btn_n), 32'h3);
        check("rst_pulses", 32'({o_press, o_release, o_long}), 32'h0);
        rst = 1'b0;
        i_btn_n = 2'b10;
        cyc = 0;
        run_to(9);
        check("pend_btn", 32'(o_btn_n), 32'h3);
        rst = 1'b1;
        #1;
        check("midrst_btn", 32'(o_btn_n), 32'h3);
        check("midrst_pulses", 32'({o_press, o_release, o_long}), 32'h0);
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        run_to(4);
        check("no_stale_credit", 32'(o_btn_n), 32'h3);
        run_to(11);
        check("press_early_btn", 32'(o_btn_n), 32'h3);
        check("press_early_pulse", 32'(o_press), 32'h0);
        run_to(12);
        check("press_btn", 32'(o_btn_n), 32'h2);
        check("press_pulse", 32'(o_press), 32'h1);
        run_to(13);
        check("press_pulse_end", 32'(o_press), 32'h0);
        check("press_count", 32'(n_press0), 32'd1);
        check("fall_count0", 32'(n_fall0), 32'd1);
        check("fall_count1", 32'(n_fall1), 32'd0);
        run_to(43);
        check("long_early", 32'(o_long), 32'h0);
        run_to(44);
        check("long_pulse", 32'(o_long), 32'h1);
        run_to(90);
        check("long_once", 32'(n_long0), 32'd1);
        i_btn_n = 2'b11;
        run_to(103);
        check("rel_early_btn", 32'(o_btn_n), 32'h2);
        check("rel_early_pulse", 32'(o_release), 32'h0);
        run_to(104);
        check("rel_btn", 32'(o_btn_n), 32'h3);
        check("rel_pulse", 32'(o_release), 32'h1);
        i_btn_n = 2'b10;
        run_to(116);
        check("press2_btn", 32'(o_btn_n), 32'h2);
        check("press2_pulse", 32'(o_press), 32'h1);
        run_to(147);
        check("long2_early", 32'(o_long), 32'h0);
        run_to(148);
        check("long2_pulse", 32'(o_long), 32'h1);
        check("long2_count", 32'(n_long0), 32'd2);
        i_btn_n = 2'b11;
        run_to(160);
        check("rel2_btn", 32'(o_btn_n), 32'h3);
        check("rel2_pulse", 32'(o_release), 32'h1);
        p0 = n_press0;
        r0 = n_rel0;
        l0 = n_low0;
        f0 = n_fall0;
        for (int k = 0; k < 12; k++) begin
            i_btn_n = {1'b1, k % 2 == 1};
            run_to(165 + 5 * k);
        end
        i_btn_n = 2'b11;
        run_to(240);
        check("bounce_no_press", 32'(n_press0 - p0), 32'd0);
        check("bounce_no_release", 32'(n_rel0 - r0), 32'd0);
        check("bounce_level_held", 32'(n_low0 - l0), 32'd0);
        check("bounce_no_fall", 32'(n_fall0 - f0), 32'd0);
        i_btn_n = 2'b10;
        run_to(248);
        i_btn_n = 2'b11;
        step();
        i_btn_n = 2'b10;
        run_to(252);
        check("glitch_no_accept", 32'(o_btn_n), 32'h3);
        run_to(259);
        check("glitch_late_btn", 32'(o_btn_n), 32'h3);
        run_to(260);
        check("glitch_accept_btn", 32'(o_btn_n), 32'h2);
        check("glitch_accept_pulse", 32'(o_press), 32'h1);
        i_btn_n = 2'b11;
        run_to(272);
        check("rel3_btn", 32'(o_btn_n), 32'h3);
        i_btn_n = 2'b00;
        run_to(284);
        check("both_press", 32'(o_press), 32'h3);
        check("both_btn", 32'(o_btn_n), 32'h0);
        i_btn_n = 2'b10;
        run_to(296);
        check("rel1_pulse", 32'(o_release), 32'h2);
        check("rel1_btn", 32'(o_btn_n), 32'h2);
        run_to(316);
        check("long_btn0_only", 32'(o_long), 32'h1);
        i_btn_n = 2'b11;
        run_to(328);
        check("final_btn", 32'(o_btn_n), 32'h3);
        check("final_rel", 32'(o_release), 32'h1);
        check("press1_count", 32'(n_press1), 32'd1);
        check("long1_none", 32'(n_long1), 32'd0);
        check("press_rel_exclusive", 32'(n_both), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
